// File: rtl/uart_rx_frame.sv
// UART receiver: 8N1 frames sampled at mid-bit, one-entry holding register
// with read handshake, sticky framing-error and overrun flags.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       read,
   output logic [7:0] data_out,
   output logic       data_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        r_state;
   state_t        w_state_n;
   logic          r_rx_m;
   logic          r_rx_s;
   logic          r_rx_s_d;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_n;
   logic [2:0]    r_idx;
   logic [2:0]    w_idx_n;
   logic [7:0]    r_sr;
   logic [7:0]    w_sr_n;
   logic          r_wait_hi;
   logic          w_wait_hi_n;
   logic          w_good;
   logic          w_bad;
   logic [7:0]    r_data;
   logic          r_ready;
   logic          r_ferr;
   logic          r_ovr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_m   <= 1'b1;
         r_rx_s   <= 1'b1;
         r_rx_s_d <= 1'b1;
      end else begin
         r_rx_m   <= rx;
         r_rx_s   <= r_rx_m;
         r_rx_s_d <= r_rx_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_sr      <= '0;
         r_wait_hi <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_cnt     <= w_cnt_n;
         r_idx     <= w_idx_n;
         r_sr      <= w_sr_n;
         r_wait_hi <= w_wait_hi_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt + CW'(1);
      w_idx_n     = r_idx;
      w_sr_n      = r_sr;
      w_wait_hi_n = r_wait_hi;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_n = '0;
            // after a low stop bit, the line must go high before a new start
            if (r_wait_hi) begin
               if (r_rx_s) w_wait_hi_n = 1'b0;
            end else if (r_rx_s_d && !r_rx_s) begin
               w_state_n = S_START;
            end
         end
         S_START: begin
            if (r_cnt == C_HALF) begin
               w_cnt_n = '0;
               if (!r_rx_s) begin
                  w_state_n = S_DATA;
                  w_idx_n   = '0;
               end else begin
                  w_state_n = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (r_cnt == C_LAST) begin
               w_cnt_n = '0;
               w_sr_n  = {r_rx_s, r_sr[7:1]};
               if (r_idx == 3'd7) w_state_n = S_STOP;
               else               w_idx_n   = r_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (r_cnt == C_LAST) begin
               w_cnt_n   = '0;
               w_state_n = S_IDLE;
               if (r_rx_s) begin
                  w_good = 1'b1;
               end else begin
                  w_bad       = 1'b1;
                  w_wait_hi_n = 1'b1;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_ready <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         if (read) begin
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
         end
         if (w_bad) r_ferr <= 1'b1;
         // a new byte completing alongside read wins over the clear
         if (w_good) begin
            r_data  <= r_sr;
            r_ready <= 1'b1;
            if (r_ready && !read) r_ovr <= 1'b1;
         end
      end
   end

   assign data_out   = r_data;
   assign data_ready = r_ready;
   assign frame_err  = r_ferr;
   assign overrun    = r_ovr;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: timing, glitch, framing error,
// overrun, read collision and mid-frame reset.
module tb_uart_rx_frame;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       read = 1'b0;
   logic [7:0] data_out;
   logic       data_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_chk = 0;
   int n_err = 0;

   uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .read      (read),
      .data_out  (data_out),
      .data_ready(data_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // start bit, 8 data bits LSB first, stop bit; rx left at the stop level
   task automatic send_frame(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         cycles(CPB);
      end
      rx = stop;
      cycles(CPB);
   endtask

   task automatic pulse_read();
      read = 1'b1;
      cycles(1);
      read = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(2);
   endtask

   int busy_n;

   initial begin
      do_reset();
      check("rst_data", data_out, 0);
      check("rst_ready", data_ready, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_busy", busy, 0);

      // 0xA5: data_ready rises exactly 155 cycles after rx falls
      fork
         send_frame(8'hA5, 1'b1);
         begin
            cycles(154);
            check("a5_early", data_ready, 0);
            cycles(1);
            check("a5_ready", data_ready, 1);
            check("a5_data", data_out, 8'hA5);
            check("a5_ferr", frame_err, 0);
            check("a5_busy", busy, 0);
         end
      join
      pulse_read();
      check("a5_read", data_ready, 0);
      cycles(10);

      // glitch of 4 cycles is rejected after ~8 busy cycles
      busy_n = 0;
      rx = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 4) rx = 1'b1;
         @(negedge clk);
         if (busy) busy_n++;
      end
      check("glitch_busy", busy_n, 8);
      check("glitch_ready", data_ready, 0);
      send_frame(8'h3C, 1'b1);
      cycles(4);
      check("after_glitch", data_out, 8'h3C);
      check("after_glitch_rdy", data_ready, 1);

      // bad stop bit then a long break
      do_reset();
      send_frame(8'h3C, 1'b0);
      cycles(2);
      check("ferr_set", frame_err, 1);
      check("ferr_ready", data_ready, 0);
      check("ferr_data", data_out, 0);
      pulse_read();
      check("ferr_clr", frame_err, 0);
      cycles(40 * CPB);
      check("break_ferr", frame_err, 0);
      check("break_busy", busy, 0);
      rx = 1'b1;
      cycles(2 * CPB);

      // back-to-back frames without read
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      cycles(2);
      check("ovr_data", data_out, 8'h22);
      check("ovr_ready", data_ready, 1);
      check("ovr_flag", overrun, 1);
      pulse_read();
      check("ovr_clr_rdy", data_ready, 0);
      check("ovr_clr_ovr", overrun, 0);
      check("ovr_clr_fe", frame_err, 0);
      cycles(5);

      // read collides with completion of the next good frame
      send_frame(8'h66, 1'b1);
      cycles(5);
      fork
         send_frame(8'h77, 1'b1);
         begin
            cycles(154);
            read = 1'b1;
            cycles(1);
            read = 1'b0;
         end
      join
      cycles(2);
      check("coll_data", data_out, 8'h77);
      check("coll_ready", data_ready, 1);
      check("coll_ovr", overrun, 0);

      // asynchronous reset in the middle of data bit 4
      fork
         send_frame(8'hC3, 1'b1);
         begin
            cycles(88);
            #1 rst = 1'b1;
            #1;
            check("arst_data", data_out, 0);
            check("arst_ready", data_ready, 0);
            check("arst_busy", busy, 0);
            check("arst_ovr", overrun, 0);
            check("arst_fe", frame_err, 0);
         end
      join
      cycles(3);
      rst = 1'b0;
      cycles(5);
      send_frame(8'h5A, 1'b1);
      cycles(2);
      check("post_rst_data", data_out, 8'h5A);
      check("post_rst_rdy", data_ready, 1);
      check("post_rst_fe", frame_err, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
